// File: rtl/boolean_propose_scheduler.sv
// -----------------------------------------------------------------------------
// boolean_propose_scheduler
//
// Purpose:
//   Sequences a run of single-bit-flip proposals over an N_VARS-bit boolean
//   assignment. Each proposal flips one indexed bit of the committed
//   assignment. The proposal is held until an external evaluator returns an
//   accept/reject decision. Accepted proposals become the new committed
//   assignment, and the block counts how many were accepted.
//
// Configuration macro:
//   RANDOM_INDEX_EN - when defined, the flip index comes from a 16-bit
//                     Fibonacci LFSR (taps 16,14,13,11). When undefined, it
//                     comes from a free-running round-robin counter.
//
// Parameters:
//   N_VARS  - number of boolean variables (>= 2)
//   IDX_W   - index width, ceil(log2(N_VARS))
//   ITER_W  - iteration / accept-count width
//   SEED    - nonzero LFSR reset value
//
// Ports:
//   in_clk                           rising-edge clock
//   in_reset                         asynchronous active-high reset
//   in_start                         begin a run (sampled in IDLE only)
//   in_initial_assignment            starting assignment, [0:N_VARS-1]
//   in_num_iterations                proposals per run (captured at start)
//   in_accept_valid                  evaluator decision present
//   in_accept                        1 = accept, 0 = reject
//   out_variable_to_be_changed_index index of the bit being flipped
//   out_propose_enable               one-cycle pulse in PROPOSE
//   out_proposed_assignment          current assignment with indexed bit flipped
//   out_proposal_valid               proposal awaits a decision
//   out_current_assignment           committed assignment
//   out_busy                         high whenever not IDLE
//   out_done                         one-cycle pulse at end of run
//   out_accept_count                 accepted proposals in current/last run
//
// Bit i of a [0:N_VARS-1] vector is addressed by index i, so index 0 is the
// leftmost bit.
// -----------------------------------------------------------------------------
module boolean_propose_scheduler #(
    parameter int          N_VARS = 2,
    parameter int          IDX_W  = 1,
    parameter int          ITER_W = 8,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_start,
    input  logic [0:N_VARS-1] in_initial_assignment,
    input  logic [ITER_W-1:0] in_num_iterations,
    input  logic              in_accept_valid,
    input  logic              in_accept,
    output logic [IDX_W-1:0]  out_variable_to_be_changed_index,
    output logic              out_propose_enable,
    output logic [0:N_VARS-1] out_proposed_assignment,
    output logic              out_proposal_valid,
    output logic [0:N_VARS-1] out_current_assignment,
    output logic              out_busy,
    output logic              out_done,
    output logic [ITER_W-1:0] out_accept_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROPOSE,
        S_WAIT_DECISION,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VARS - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              state_q;
    logic [0:N_VARS-1]   current_q;
    logic [ITER_W-1:0]   iter_q;
    logic [ITER_W-1:0]   num_iter_q;
    logic [ITER_W-1:0]   accept_count_q;
    logic [IDX_W-1:0]    index_q;
    logic [IDX_W-1:0]    rr_q;
    logic [15:0]         lfsr_q;
    logic                propose_en_q;
    logic                proposal_valid_q;
    logic                busy_q;
    logic                done_q;

    // -------------------------------------------------------------------------
    // Next-value helpers
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    rr_d;
    logic [15:0]         lfsr_d;
    logic [IDX_W-1:0]    index_src_d;
    logic [0:N_VARS-1]   proposed_d;
    logic                last_iter_d;

    // Both index sources run in every build so their reset and advance
    // behaviour is identical regardless of which one drives the index.
    assign rr_d   = (rr_q == LAST_IDX) ? '0 : rr_q + IDX_W'(1);
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef RANDOM_INDEX_EN
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_VARS);
    logic [IDX_W:0] cand_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cand_d      = {1'b0, lfsr_q[IDX_W-1:0]};
        index_src_d = lfsr_q[IDX_W-1:0];
        // Candidate is below 2^IDX_W < 2*N_VARS, so one subtraction folds it
        // into range.
        if (cand_d >= N_EXT) begin
            index_src_d = IDX_W'(cand_d - N_EXT);
        end
    end
`else
    always_comb begin
        index_src_d = rr_q;
    end
`endif

    always_comb begin
        proposed_d          = current_q;
        proposed_d[index_q] = ~current_q[index_q];
    end

    // Widened by one bit so iter+1 cannot wrap when the run length is the
    // maximum representable count.
    assign last_iter_d = (({1'b0, iter_q} + (ITER_W + 1)'(1)) == {1'b0, num_iter_q});

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q          <= S_IDLE;
            current_q        <= '0;
            iter_q           <= '0;
            num_iter_q       <= '0;
            accept_count_q   <= '0;
            index_q          <= '0;
            rr_q             <= '0;
            lfsr_q           <= SEED;
            propose_en_q     <= 1'b0;
            proposal_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            // Pulses default low; set only on the transition that needs them.
            propose_en_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (in_start) begin
                        current_q      <= in_initial_assignment;
                        iter_q         <= '0;
                        accept_count_q <= '0;
                        num_iter_q     <= in_num_iterations;
                        busy_q         <= 1'b1;
                        if (in_num_iterations == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= S_PROPOSE;
                            propose_en_q <= 1'b1;
                        end
                    end
                end

                S_PROPOSE: begin
                    index_q          <= index_src_d;
                    rr_q             <= rr_d;
                    lfsr_q           <= lfsr_d;
                    proposal_valid_q <= 1'b1;
                    state_q          <= S_WAIT_DECISION;
                end

                S_WAIT_DECISION: begin
                    if (in_accept_valid) begin
                        proposal_valid_q <= 1'b0;
                        if (in_accept) begin
                            current_q      <= proposed_d;
                            accept_count_q <= accept_count_q + ITER_W'(1);
                        end
                        if (last_iter_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            iter_q       <= iter_q + ITER_W'(1);
                            state_q      <= S_PROPOSE;
                            propose_en_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_variable_to_be_changed_index = index_q;
    assign out_propose_enable               = propose_en_q;
    assign out_proposal_valid               = proposal_valid_q;
    assign out_current_assignment           = current_q;
    assign out_busy                         = busy_q;
    assign out_done                         = done_q;
    assign out_accept_count                 = accept_count_q;

    // The proposal is only meaningful while a decision is pending. Gating it
    // keeps the output all-zero in reset and between proposals.
    assign out_proposed_assignment = proposal_valid_q ? proposed_d : '0;

endmodule

// File: tb/tb_boolean_propose_scheduler.sv
// -----------------------------------------------------------------------------
// tb_boolean_propose_scheduler
//
// Directed bench for boolean_propose_scheduler. A 2-variable instance covers
// the run scenarios. A 3-variable instance runs a 200-proposal run to exercise
// index range and coverage. Expected proposals are queued when a run is
// launched and popped as the DUT presents each one. The index model follows
// RANDOM_INDEX_EN, matching the way the design is built.
// -----------------------------------------------------------------------------
module tb_boolean_propose_scheduler;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 2-variable instance
    logic       start, av, acc;
    logic [0:1] init;
    logic [7:0] num;
    logic [0:0] idx;
    logic       pe, pv, busy, done;
    logic [0:1] prop, cur;
    logic [7:0] acnt;

    // 3-variable instance
    logic       start3, av3, acc3;
    logic [0:2] init3;
    logic [7:0] num3;
    logic [1:0] idx3;
    logic       pe3, pv3, busy3, done3;
    logic [0:2] prop3, cur3;
    logic [7:0] acnt3;

    boolean_propose_scheduler #(.N_VARS(2), .IDX_W(1), .ITER_W(8), .SEED(SEED)) dut (
        .in_clk                           (clk),
        .in_reset                         (rst),
        .in_start                         (start),
        .in_initial_assignment            (init),
        .in_num_iterations                (num),
        .in_accept_valid                  (av),
        .in_accept                        (acc),
        .out_variable_to_be_changed_index (idx),
        .out_propose_enable               (pe),
        .out_proposed_assignment          (prop),
        .out_proposal_valid               (pv),
        .out_current_assignment           (cur),
        .out_busy                         (busy),
        .out_done                         (done),
        .out_accept_count                 (acnt)
    );

    boolean_propose_scheduler #(.N_VARS(3), .IDX_W(2), .ITER_W(8), .SEED(SEED)) dut3 (
        .in_clk                           (clk),
        .in_reset                         (rst),
        .in_start                         (start3),
        .in_initial_assignment            (init3),
        .in_num_iterations                (num3),
        .in_accept_valid                  (av3),
        .in_accept                        (acc3),
        .out_variable_to_be_changed_index (idx3),
        .out_propose_enable               (pe3),
        .out_proposed_assignment          (prop3),
        .out_proposal_valid               (pv3),
        .out_current_assignment           (cur3),
        .out_busy                         (busy3),
        .out_done                         (done3),
        .out_accept_count                 (acnt3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int idx;
        int prop;
    } exp_t;
    exp_t sb[$];

    // Index-source models (one per instance)
    logic [15:0] lfsr2, lfsr3;
    int          rr2, rr3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the next index of an n-variable instance and advances its model.
    task automatic pick(input int n, input int idxw, inout logic [15:0] l, inout int rr,
                        output int idx_o);
        int cand;
        cand = int'(l) & ((1 << idxw) - 1);
`ifdef RANDOM_INDEX_EN
        idx_o = (cand >= n) ? cand - n : cand;
`else
        idx_o = rr;
`endif
        rr = (rr + 1) % n;
        l  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endtask

    // One run on the 2-variable instance. acc_mask[k] is the decision for
    // proposal k; hold delays each decision by that many WAIT cycles while
    // in_start is pulsed to show it is ignored.
    task automatic run_main(input logic [1:0] init_v, input int n, input logic [7:0] acc_mask,
                            input int hold);
        int   cur_m;
        int   acc_m;
        int   i;
        exp_t e;
        cur_m = int'(init_v);
        acc_m = 0;
        for (int k = 0; k < n; k++) begin
            pick(2, 1, lfsr2, rr2, i);
            e.idx  = i;
            e.prop = cur_m ^ (1 << (1 - i));
            sb.push_back(e);
            if (acc_mask[k]) begin
                cur_m = e.prop;
                acc_m++;
            end
        end

        init  = init_v;
        num   = 8'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        num   = 8'hFF;              // must not affect the run in progress
        check("busy_after_start", busy, 1'b1);

        for (int k = 0; k < n; k++) begin
            check("propose_enable", pe, 1'b1);
            check("no_valid_in_propose", pv, 1'b0);
            tick;
            e = sb.pop_front();
            check("proposal_valid", pv, 1'b1);
            check("index", 32'(idx), 32'(e.idx));
            check("proposal", 32'(prop), 32'(e.prop));
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                tick;
                start = 1'b0;
                check("hold_valid", pv, 1'b1);
                check("hold_proposal", 32'(prop), 32'(e.prop));
                check("hold_no_enable", pe, 1'b0);
            end
            av  = 1'b1;
            acc = acc_mask[k];
            tick;
            av  = 1'b0;
            acc = 1'b0;
        end

        check("done_pulse", done, 1'b1);
        check("done_no_enable", pe, 1'b0);
        check("final_current", 32'(cur), 32'(cur_m));
        check("final_accept_count", 32'(acnt), 32'(acc_m));
        tick;
        check("done_clears", done, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("current_held", 32'(cur), 32'(cur_m));
        check("accept_count_held", 32'(acnt), 32'(acc_m));
    endtask

    initial begin
        int       i;
        int       cur_m;
        int       acc_m;
        int       seen[3];
        exp_t     e;
        logic     a;

        rst = 1'b1;
        start = 1'b0; init = '0; num = '0; av = 1'b0; acc = 1'b0;
        start3 = 1'b0; init3 = '0; num3 = '0; av3 = 1'b0; acc3 = 1'b0;
        lfsr2 = SEED; lfsr3 = SEED; rr2 = 0; rr3 = 0;
        seen = '{0, 0, 0};

        // Reset state
        #12;
        check("rst_index", 32'(idx), 0);
        check("rst_enable", pe, 0);
        check("rst_valid", pv, 0);
        check("rst_proposal", 32'(prop), 0);
        check("rst_current", 32'(cur), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_accept_count", 32'(acnt), 0);
        tick;
        rst = 1'b0;
        tick;

        // initial=00, two proposals, accept both
        run_main(2'b00, 2, 8'b11, 0);
        // initial=01, one proposal, reject
        run_main(2'b01, 1, 8'b0, 0);
        // zero iterations: straight to DONE, no proposal
        run_main(2'b10, 0, 8'b0, 0);
        // decision delayed 5 cycles with in_start pulses during the wait
        run_main(2'b10, 1, 8'b1, 5);

        // Reset while in WAIT_DECISION
        init  = 2'b11;
        num   = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("pre_reset_valid", pv, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_index", 32'(idx), 0);
        check("mid_rst_enable", pe, 0);
        check("mid_rst_valid", pv, 0);
        check("mid_rst_proposal", 32'(prop), 0);
        check("mid_rst_current", 32'(cur), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_accept_count", 32'(acnt), 0);
        lfsr2 = SEED; lfsr3 = SEED; rr2 = 0; rr3 = 0;
        tick;
        rst = 1'b0;
        av  = 1'b1;                 // stray decision in IDLE must be ignored
        acc = 1'b1;
        tick;
        av  = 1'b0;
        acc = 1'b0;
        check("post_rst_no_pending", pv, 1'b0);
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_current", 32'(cur), 0);
        run_main(2'b01, 2, 8'b01, 0);

        // 3-variable instance: 200 proposals, random decisions
        cur_m  = 0;
        acc_m  = 0;
        init3  = 3'b000;
        num3   = 8'd200;
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            pick(3, 2, lfsr3, rr3, i);
            e.idx  = i;
            e.prop = cur_m ^ (1 << (2 - i));
            sb.push_back(e);
            check("n3_enable", pe3, 1'b1);
            tick;
            e = sb.pop_front();
            check("n3_valid", pv3, 1'b1);
            check("n3_index_range", 32'(idx3 < 2'd3), 1);
            check("n3_index", 32'(idx3), 32'(e.idx));
            check("n3_proposal", 32'(prop3), 32'(e.prop));
            if (idx3 < 2'd3) seen[idx3] = 1;
            a = 1'($urandom_range(0, 1));
            if (a) begin
                cur_m = e.prop;
                acc_m++;
            end
            av3  = 1'b1;
            acc3 = a;
            tick;
            av3  = 1'b0;
            acc3 = 1'b0;
        end
        check("n3_done", done3, 1'b1);
        check("n3_current", 32'(cur3), 32'(cur_m));
        check("n3_accept_count", 32'(acnt3), 32'(acc_m));
        for (int v = 0; v < 3; v++) begin
            check($sformatf("n3_seen_%0d", v), 32'(seen[v]), 1);
        end
        tick;
        check("n3_idle", busy3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boolean_propose_scheduler.md
BOOLEAN_PROPOSE_SCHEDULER -- requirements
Module: boolean_propose_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named in_clk and in_reset.
REQ-002 Parameter N_VARS SHALL default to 2 and sets the number of boolean variables, with N_VARS >= 2.
REQ-003 Parameter IDX_W SHALL default to 1 and sets the index width, equal to ceil(log2(N_VARS)).
REQ-004 Parameter ITER_W SHALL default to 8 and sets the iteration-count width.
REQ-005 Parameter SEED SHALL default to 16'hACE1 and sets the LFSR reset value; it SHALL be nonzero.
REQ-006 Port in_clk: input, 1 bit, rising-edge clock.
REQ-007 Port in_reset: input, 1 bit, asynchronous active-high reset.
REQ-008 Port in_start: input, 1 bit, begins a run; sampled in IDLE only.
REQ-009 Port in_initial_assignment: input, [0:N_VARS-1], starting assignment.
REQ-010 Port in_num_iterations: input, ITER_W bits, number of proposals in a run.
REQ-011 Port in_accept_valid: input, 1 bit, the evaluator decision is present.
REQ-012 Port in_accept: input, 1 bit, 1 = accept the proposal, 0 = reject it.
REQ-013 Port out_variable_to_be_changed_index: output, IDX_W bits, the index of the bit to flip.
REQ-014 Port out_propose_enable: output, 1 bit, the enable pulse to the proposer.
REQ-015 Port out_proposed_assignment: output, [0:N_VARS-1], the current assignment with the indexed bit inverted.
REQ-016 Port out_proposal_valid: output, 1 bit, the proposal awaits a decision.
REQ-017 Port out_current_assignment: output, [0:N_VARS-1], the committed assignment.
REQ-018 Port out_busy: output, 1 bit, high in any state other than IDLE.
REQ-019 Port out_done: output, 1 bit, a one-cycle pulse at the end of a run.
REQ-020 Port out_accept_count: output, ITER_W bits, the number of accepted proposals in the current or last run.

Function
REQ-021 The FSM SHALL have the states IDLE, PROPOSE, WAIT_DECISION and DONE, and SHALL be encoded in registers.
REQ-022 In IDLE, when in_start=1, the block SHALL set current to in_initial_assignment, set the iteration counter to 0 and the accept count to 0, and go to PROPOSE; if in_num_iterations=0 it SHALL go to DONE instead.
REQ-023 PROPOSE SHALL last 1 cycle: the index register is loaded from the index source and out_propose_enable=1, then the FSM goes to WAIT_DECISION.
REQ-024 In WAIT_DECISION, out_proposal_valid=1 and out_proposed_assignment SHALL be held stable until in_accept_valid=1.
REQ-025 On in_accept_valid=1 in WAIT_DECISION with in_accept=1, current SHALL take the proposed assignment and the accept count SHALL increment, both in the same edge.
REQ-026 On in_accept_valid=1 in WAIT_DECISION with in_accept=0, current SHALL be unchanged.
REQ-027 After a decision, if iterations+1 == in_num_iterations the FSM SHALL go to DONE, otherwise it SHALL increment the iteration counter and go to PROPOSE.
REQ-028 The minimum period per proposal SHALL be 2 cycles, when in_accept_valid is present in the first WAIT_DECISION cycle.
REQ-029 DONE SHALL last 1 cycle with out_done=1, then the FSM returns to IDLE; current and the accept count SHALL hold until the next in_start.
REQ-030 in_start outside IDLE and in_accept_valid outside WAIT_DECISION SHALL be ignored.
REQ-031 in_num_iterations SHALL be captured at start, so changes during a run have no effect.
REQ-032 Index i SHALL address bit i of a [0:N_VARS-1] vector, so index 0 is the leftmost bit.
REQ-033 out_proposed_assignment SHALL be combinational from current and the index register.
REQ-034 The emitted index SHALL always be less than N_VARS.

Reset
REQ-035 Asserting in_reset at any time, including mid-run, SHALL give state=IDLE and LFSR=SEED.
REQ-036 Under reset, every output and counter SHALL be 0 (index, out_propose_enable, out_proposal_valid, out_proposed_assignment, out_current_assignment, out_busy, out_done, out_accept_count, and the iteration and round-robin counters).
REQ-037 There SHALL be no pending decision after reset is released.

Configuration
REQ-038 With the macro RANDOM_INDEX_EN defined, the index SHALL come from a 16-bit Fibonacci LFSR with taps 16,14,13,11.
REQ-039 With RANDOM_INDEX_EN defined, the LFSR SHALL advance once per PROPOSE cycle.
REQ-040 With RANDOM_INDEX_EN defined, the candidate index SHALL be lfsr[IDX_W-1:0]; if the candidate is >= N_VARS the index SHALL be candidate-N_VARS.
REQ-041 Without RANDOM_INDEX_EN, the index SHALL come from a round-robin counter that counts 0,1,...,N_VARS-1 and wraps to 0.
REQ-042 Without RANDOM_INDEX_EN, the counter SHALL advance once per PROPOSE cycle and SHALL NOT be cleared by in_start.

Verification
REQ-043 Scenario (macro off, N_VARS=2): initial=00, iterations=2, accept both -> index 0 then 1; proposals 10 then 11; final current=11; accept_count=2; out_done for 1 cycle.
REQ-044 Scenario (macro off): initial=01, iterations=1, in_accept=0 -> proposal 11, final current=01, accept_count=0.
REQ-045 Scenario: in_num_iterations=0 with in_start -> DONE on the next cycle; current=initial; no out_propose_enable pulse.
REQ-046 Scenario: delay in_accept_valid by 5 cycles -> out_proposal_valid and the proposal held stable for all 5; in_start pulses during the run are ignored.
REQ-047 Scenario: assert in_reset while in WAIT_DECISION -> all outputs 0 and state IDLE immediately (asynchronously); a new in_start runs normally.
REQ-048 Scenario (macro on, N_VARS=3, IDX_W=2): 200 iterations -> every index is less than 3 and every value 0..2 is seen at least once.
